// File: rtl/missiles_pkg.sv
// Shared coordinate and slot types for the missile scheduler.
// A slot record carries the live flag plus the signed top-left position.
package missiles_pkg;

    localparam int COORD_WIDTH = 11;

    typedef logic signed [COORD_WIDTH-1:0] coord_t;

    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
    } missile_slot_t;

endpackage

// File: rtl/missile_slot.sv
// One missile slot: holds active/X/Y and applies launch, per-frame move,
// top-of-screen retire and collision hit.
module missile_slot
    import missiles_pkg::*;
#(
    parameter int MISSILE_SPEED = 4,
    parameter int TOP_LIMIT     = 0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   launch,
    input  logic                   hit,
    input  logic [COORD_WIDTH-1:0] spawnX,
    input  logic [COORD_WIDTH-1:0] spawnY,
    output logic                   active,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y
);

    missile_slot_t q;
    coord_t        new_y;

    assign new_y = q.y - coord_t'(MISSILE_SPEED);

    // launch only ever targets an inactive slot, so it never races hit/move;
    // hit takes precedence over movement on a live slot
    always_ff @(posedge clk) begin
        if (!resetN) begin
            q <= '0;
        end else if (launch) begin
            q.active <= 1'b1;
            q.x      <= coord_t'(spawnX);
            q.y      <= coord_t'(spawnY);
        end else if (q.active) begin
            if (hit) begin
                q.active <= 1'b0;
            end else if (startOfFrame) begin
                if (new_y < coord_t'(TOP_LIMIT))
                    q.active <= 1'b0;
                else
                    q.y <= new_y;
            end
        end
    end

    assign active = q.active;
    assign x      = q.x;
    assign y      = q.y;

endmodule

// File: rtl/missile_slot_scheduler.sv
// Frame-paced missile pool: cooldown, lowest-free slot allocation,
// fired/denied pulses and live-slot count over NUM_SLOTS missile slots.
module missile_slot_scheduler
    import missiles_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MISSILE_SPEED   = 4,
    parameter int SPAWN_OFFSET_X  = 15,
    parameter int MISSILE_HEIGHT  = 5,
    parameter int TOP_LIMIT       = 0
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic                             fireReq,
    input  logic [10:0]                      spaceShip_X,
    input  logic [10:0]                      spaceShip_Y,
    input  logic [NUM_SLOTS-1:0]             hit,
    output logic [NUM_SLOTS-1:0]             slotActive,
    output logic [NUM_SLOTS*COORD_WIDTH-1:0] slotTopLeftX,
    output logic [NUM_SLOTS*COORD_WIDTH-1:0] slotTopLeftY,
    output logic                             fired,
    output logic                             denied,
    output logic [3:0]                       activeCount
);

    logic [3:0]             cooldown;
    logic [NUM_SLOTS-1:0]   launch_sel;
    logic                   fire_ok;
    logic                   any_free;
    logic [COORD_WIDTH-1:0] spawn_x;
    logic [COORD_WIDTH-1:0] spawn_y;

    assign fire_ok  = startOfFrame & fireReq & (cooldown == 4'd0);
    // eligibility is from registered state, so a slot hit this cycle is not reused
    assign any_free = ~&slotActive;
    assign spawn_x  = spaceShip_X + COORD_WIDTH'(SPAWN_OFFSET_X);
    assign spawn_y  = spaceShip_Y - COORD_WIDTH'(MISSILE_HEIGHT);

    // descending scan so the lowest free index is the one left selected
    always_comb begin
        launch_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slotActive[i]) begin
                launch_sel    = '0;
                launch_sel[i] = fire_ok;
            end
        end
    end

    // a denied attempt leaves cooldown at zero so the next frame retries
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cooldown <= 4'd0;
            fired    <= 1'b0;
            denied   <= 1'b0;
        end else begin
            fired  <= fire_ok & any_free;
            denied <= fire_ok & ~any_free;
            if (fire_ok & any_free)
                cooldown <= 4'(COOLDOWN_FRAMES);
            else if (startOfFrame && cooldown != 4'd0)
                cooldown <= cooldown - 4'd1;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        missile_slot #(
            .MISSILE_SPEED (MISSILE_SPEED),
            .TOP_LIMIT     (TOP_LIMIT)
        ) u_slot (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .launch       (launch_sel[g]),
            .hit          (hit[g]),
            .spawnX       (spawn_x),
            .spawnY       (spawn_y),
            .active       (slotActive[g]),
            .x            (slotTopLeftX[g*COORD_WIDTH +: COORD_WIDTH]),
            .y            (slotTopLeftY[g*COORD_WIDTH +: COORD_WIDTH])
        );
    end

    always_comb begin
        activeCount = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            activeCount = activeCount + {3'b000, slotActive[i]};
    end

endmodule

// File: tb/tb_missile_slot_scheduler.sv
// Bench for missile_slot_scheduler: directed scenarios plus random frames,
// every cycle compared against an integer model of the pool rules.
module tb_missile_slot_scheduler;

    localparam int NS  = 4;
    localparam int CD  = 8;
    localparam int SPD = 4;
    localparam int OFX = 15;
    localparam int MH  = 5;

    logic           clk = 1'b0;
    logic           resetN;
    logic           startOfFrame;
    logic           fireReq;
    logic [10:0]    spaceShip_X;
    logic [10:0]    spaceShip_Y;
    logic [NS-1:0]  hit;
    logic [NS-1:0]  slotActive;
    logic [NS*11-1:0] slotTopLeftX;
    logic [NS*11-1:0] slotTopLeftY;
    logic           fired;
    logic           denied;
    logic [3:0]     activeCount;

    missile_slot_scheduler #(
        .NUM_SLOTS(NS), .COOLDOWN_FRAMES(CD), .MISSILE_SPEED(SPD),
        .SPAWN_OFFSET_X(OFX), .MISSILE_HEIGHT(MH), .TOP_LIMIT(0)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
        .spaceShip_X(spaceShip_X), .spaceShip_Y(spaceShip_Y), .hit(hit),
        .slotActive(slotActive), .slotTopLeftX(slotTopLeftX), .slotTopLeftY(slotTopLeftY),
        .fired(fired), .denied(denied), .activeCount(activeCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference pool state
    bit m_act [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_cd;
    bit e_fired, e_denied;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit sof, input bit fire,
                                input int sx, input int sy, input logic [NS-1:0] h);
        bit prev [NS];
        int pick;
        if (!rst) begin
            foreach (m_act[i]) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
            m_cd = 0; e_fired = 0; e_denied = 0;
            return;
        end
        e_fired = 0; e_denied = 0;
        foreach (m_act[i]) prev[i] = m_act[i];
        for (int i = 0; i < NS; i++) begin
            if (prev[i] && h[i]) m_act[i] = 0;
            else if (prev[i] && sof) begin
                if (m_y[i] - SPD < 0) m_act[i] = 0;
                else m_y[i] = m_y[i] - SPD;
            end
        end
        if (sof && fire && m_cd == 0) begin
            pick = -1;
            for (int i = NS - 1; i >= 0; i--) if (!prev[i]) pick = i;
            if (pick < 0) e_denied = 1;
            else begin
                m_act[pick] = 1;
                m_x[pick] = (sx + OFX) % 2048;
                m_y[pick] = sy - MH;
                e_fired = 1;
                m_cd = CD;
            end
        end else if (sof && m_cd > 0) begin
            m_cd--;
        end
    endtask

    task automatic compare_all();
        int cnt;
        cnt = 0;
        for (int i = 0; i < NS; i++) begin
            check($sformatf("act%0d", i), int'(slotActive[i]), int'(m_act[i]));
            check($sformatf("x%0d", i), int'(slotTopLeftX[11*i +: 11]), m_x[i]);
            check($sformatf("y%0d", i), int'($signed(slotTopLeftY[11*i +: 11])), m_y[i]);
            cnt += int'(m_act[i]);
        end
        check("fired", int'(fired), int'(e_fired));
        check("denied", int'(denied), int'(e_denied));
        check("activeCount", int'(activeCount), cnt);
    endtask

    task automatic step(input bit rst, input bit sof, input bit fire, input logic [NS-1:0] h);
        resetN = rst; startOfFrame = sof; fireReq = fire; hit = h;
        @(posedge clk);
        model_update(rst, sof, fire, int'(spaceShip_X), int'(spaceShip_Y), h);
        #1;
        compare_all();
    endtask

    task automatic frame(input bit fire);
        step(1, 1, fire, '0);
        step(1, 0, fire, '0);
        step(1, 0, fire, '0);
    endtask

    initial begin
        resetN = 0; startOfFrame = 0; fireReq = 0; hit = '0;
        spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
        foreach (m_act[i]) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_cd = 0; e_fired = 0; e_denied = 0;

        // reset state
        step(0, 0, 0, '0);
        step(0, 1, 1, '1);
        check("rst_active", int'(slotActive), 0);
        check("rst_count", int'(activeCount), 0);

        // first launch from (100,400)
        step(1, 1, 1, '0);
        check("tp1_x", int'(slotTopLeftX[10:0]), 115);
        check("tp1_y", int'(slotTopLeftY[10:0]), 395);
        check("tp1_fired", int'(fired), 1);
        check("tp1_count", int'(activeCount), 1);
        step(1, 0, 0, '0);
        check("tp1_fired_drop", int'(fired), 0);

        // held fire for 40 frames
        step(0, 0, 0, '0);
        for (int f = 0; f < 40; f++) begin
            step(1, 1, 1, '0);
            if (f == 0 || f == 9 || f == 18 || f == 27)
                check($sformatf("held_fired_f%0d", f), int'(fired), 1);
            if (f == 36) begin
                check("held_denied_f36", int'(denied), 1);
                check("held_slot0_y_f36", int'($signed(slotTopLeftY[10:0])), 251);
            end
            if (f == 37) check("held_denied_f37", int'(denied), 1);
            step(1, 0, 1, '0);
            step(1, 0, 1, '0);
        end

        // single missile climbs off the top
        step(0, 0, 0, '0);
        step(1, 1, 1, '0);
        for (int f = 1; f <= 99; f++) begin
            step(1, 1, 0, '0);
            if (f == 98) check("retire_f98_y", int'($signed(slotTopLeftY[10:0])), 3);
            step(1, 0, 0, '0);
        end
        check("retire_active", int'(slotActive[0]), 0);
        check("retire_y_held", int'($signed(slotTopLeftY[10:0])), 3);

        // hit on an inactive slot, then hit coinciding with a launch
        step(0, 0, 0, '0);
        for (int f = 0; f < 18; f++) begin
            step(1, 1, 1, '0);
            step(1, 0, 1, (f == 10) ? 4'b0100 : 4'b0000);
            step(1, 0, 1, '0);
        end
        check("hit_inactive_ignored", int'(slotActive), 3);
        step(1, 1, 1, 4'b0001);
        check("hit_launch_active", int'(slotActive), 6);
        check("hit_launch_fired", int'(fired), 1);
        for (int f = 19; f < 28; f++) frame(1);
        check("three_active", int'(activeCount), 3);
        step(0, 0, 0, '0);
        check("midflight_reset", int'(slotActive), 0);
        check("midflight_count", int'(activeCount), 0);

        // random frames
        for (int f = 0; f < 400; f++) begin
            spaceShip_X = 11'($urandom_range(0, 2000));
            spaceShip_Y = 11'($urandom_range(5, 1028));
            step(1, 1, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0);
            step(($urandom_range(0, 80) != 0), 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 4) == 0) ? NS'($urandom) : '0);
            step(1, 0, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
